// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit imem words,
// appends a halt word after the image and holds the core off until loading completes.
module imem_loader #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] HALT_WORD = 32'h0000_0063
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  word_count
);

    localparam int unsigned IdxW = $clog2(DEPTH + 1);
    localparam logic [IdxW-1:0] DepthIdx = IdxW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StTerm,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [IdxW-1:0] word_idx_q, word_idx_d;
    logic [IdxW-1:0] word_idx_inc;
    logic [31:0]     asm_q, asm_d;
    logic            last_q, last_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      word_count_q, word_count_d;

    assign word_idx_inc = word_idx_q + IdxW'(1);

    // The write strobe is registered on the edge that enters WRITE/TERM, so it is
    // visible during exactly the cycle the FSM spends in that state.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        last_d       = last_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StRecv;
                    byte_idx_d   = 2'd0;
                    word_idx_d   = '0;
                    asm_d        = 32'd0;
                    last_d       = 1'b0;
                    cpu_hold_d   = 1'b1;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                    word_count_d = 8'd0;
                end
            end
            StRecv: begin
                if (in_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    last_d     = in_last;
                    if (byte_idx_q == 2'd3 || in_last) begin
                        state_d    = StWrite;
                        byte_idx_d = 2'd0;
                        if (word_idx_q < DepthIdx) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = 32'(word_idx_q) << 2;
                            wr_data_d = asm_d;
                        end
                    end
                end
            end
            StWrite: begin
                if (word_idx_q < DepthIdx) begin
                    word_idx_d   = word_idx_inc;
                    word_count_d = word_count_q + 8'd1;
                    asm_d        = 32'd0;
                    if (last_q) begin
                        state_d = StTerm;
                        // No room left for the terminator when the image fills imem.
                        if (word_idx_inc < DepthIdx) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = 32'(word_idx_inc) << 2;
                            wr_data_d = HALT_WORD;
                        end
                    end else begin
                        state_d = StRecv;
                    end
                end else begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = StDone;
                end
            end
            StTerm: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            byte_idx_q   <= 2'd0;
            word_idx_q   <= '0;
            asm_q        <= 32'd0;
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = (state_q == StRecv);
    assign busy       = (state_q == StRecv) || (state_q == StWrite) || (state_q == StTerm);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected imem writes plus
// per-scenario status checks.
module tb_imem_loader;

    localparam int unsigned DEPTH     = 128;
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  word_count;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    logic [63:0] exp_q[$];

    imem_loader #(
        .DEPTH    (DEPTH),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (busy && !in_ready) stall_cnt++;
        if (wr_en) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_during_write: got %b, required 0", in_ready);
            end
        end
    end

    // Reference model of the imem writes an image should produce.
    task automatic expect_image(input byte_q_t bytes);
        int n = bytes.size();
        int nwords = (n + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] word = 32'd0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) word[8*b +: 8] = bytes[4*w+b];
            if (w < DEPTH) exp_q.push_back({32'(w) << 2, word});
        end
        if (nwords < DEPTH) exp_q.push_back({32'(nwords) << 2, HALT_WORD});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL byte_timeout: in_ready got %b, required 1 within 50 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // start_at >= 0 injects an extra start pulse before that byte index.
    task automatic send_image(input byte_q_t bytes, input bit throttle, input int start_at);
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(bytes[i], (i == bytes.size() - 1),
                      throttle ? 2 + int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic wait_done(input string name, input logic [7:0] exp_wc, input logic exp_ovf);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got %b, required 1", name, done);
        end
        checks++;
        if ({busy, cpu_hold} !== 2'b00) begin
            errors++;
            $display("FAIL %s_release: busy/cpu_hold got %b, required 00", name, {busy, cpu_hold});
        end
        checks++;
        if (word_count !== exp_wc) begin
            errors++;
            $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, exp_wc);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s_overflow: got %b, required %b", name, overflow, exp_ovf);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, overflow, word_count}
            !== '0) begin
            errors++;
            $display("FAIL %s: got rdy=%b wr=%b a=%h d=%h hold=%b busy=%b done=%b ovf=%b wc=%0d, required all 0",
                     name, in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, overflow,
                     word_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        byte_q_t img = '{8'h13, 8'h05, 8'h00, 8'h00};
        expect_image(img);
        pulse_start();
        checks++;
        if ({busy, cpu_hold, in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL basic_started: busy/hold/ready got %b, required 111",
                     {busy, cpu_hold, in_ready});
        end
        send_image(img, 1'b0, -1);
        wait_done("basic", 8'd1, 1'b0);
    endtask

    task automatic test_partial_word();
        byte_q_t img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        expect_image(img);
        pulse_start();
        send_image(img, 1'b0, -1);
        wait_done("partial", 8'd2, 1'b0);
    endtask

    task automatic test_throttled();
        byte_q_t img = '{8'h13, 8'h05, 8'h00, 8'h00};
        expect_image(img);
        pulse_start();
        stall_cnt = 0;
        send_image(img, 1'b1, -1);
        wait_done("throttled", 8'd1, 1'b0);
        checks++;
        if (stall_cnt != 2) begin
            errors++;
            $display("FAIL throttled_stalls: got %0d not-ready busy cycles, required 2", stall_cnt);
        end
    endtask

    task automatic test_full_and_overflow();
        byte_q_t img;
        for (int i = 0; i < 4 * DEPTH; i++) img.push_back(8'((i * 7 + 3) & 255));
        expect_image(img);
        pulse_start();
        send_image(img, 1'b0, -1);
        wait_done("full", 8'(DEPTH), 1'b0);
        for (int i = 0; i < 4; i++) img.push_back(8'hE0 + 8'(i));
        expect_image(img);
        pulse_start();
        send_image(img, 1'b0, -1);
        wait_done("overflow", 8'(DEPTH), 1'b1);
    endtask

    task automatic test_start_busy_and_restart();
        byte_q_t img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        byte_q_t img1 = '{8'h13, 8'h05, 8'h00, 8'h00};
        // Comes straight after the overflow load: restart must clear sticky flags.
        pulse_start();
        checks++;
        if ({done, overflow, word_count, cpu_hold, busy} !== {2'b00, 8'd0, 2'b11}) begin
            errors++;
            $display("FAIL restart_clear: done=%b ovf=%b wc=%0d hold=%b busy=%b, required 0 0 0 1 1",
                     done, overflow, word_count, cpu_hold, busy);
        end
        expect_image(img1);
        send_image(img1, 1'b0, -1);
        wait_done("restart", 8'd1, 1'b0);
        expect_image(img);
        pulse_start();
        send_image(img, 1'b0, 2);
        wait_done("start_busy", 8'd2, 1'b0);
    endtask

    task automatic test_reset_midload();
        byte_q_t img = '{8'h13, 8'h05, 8'h00, 8'h00};
        pulse_start();
        send_byte(8'h77, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_midload");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_image(img);
        pulse_start();
        send_image(img, 1'b0, -1);
        wait_done("after_reset", 8'd1, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        test_reset();
        test_basic();
        test_partial_word();
        test_throttled();
        test_full_and_overflow();
        test_start_busy_and_restart();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
